conv_operand_feeder: RTL and testbench
======================================

# conv_operand_feeder

Upstream operand feeder for a linear chain of N `singlePE` stages in the convolution datapath. Per job it loads N 8-bit weights into the chain's b-registers with `feed_b_en` pulses, then streams a programmed number of 8-bit activations out of an internal FIFO. It then flushes the chain with zero operands and signals completion. All outputs are registered and drive the first PE's `in_a`, `in_b`, `b_en` and `p_sum` directly.

## Interface
- `N`, default 3: number of PEs in the chain; weights per job and flush length.
- `DEPTH`, default 16: activation FIFO depth (power of two, ≥2).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous active-low reset (0 = reset); one clock, reset asserts asynchronously.
- `start`  in  1  job start pulse; honoured only in IDLE.
- `len`  in  8  activations in the job; sampled with `start`.
- `bias`  in  8  partial-sum seed; sampled with `start` (used only with `CONV_FEEDER_BIAS_EN`).
- `w_valid` / `w_ready` / `w_data`  in / out / in  1/1/8  weight handshake.
- `a_valid` / `a_ready` / `a_data`  in / out / in  1/1/8  activation handshake into the FIFO.
- `feed_a`  out  8  to PE `in_a`.
- `feed_b`  out  8  to PE `in_b`.
- `feed_b_en`  out  1  to PE `b_en`.
- `feed_psum`  out  8  to PE `p_sum`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD_W, STREAM, FLUSH, DONE.
- IDLE: `start`=1 latches `len` and `bias`, clears the weight and flush counters, and moves to LOAD_W.
- LOAD_W:
  - `w_ready`=1.
  - Each accepted weight registers `feed_b`←`w_data` and `feed_b_en`←1 for the next cycle.
  - A cycle with no accepted weight drives `feed_b_en`=0 and holds `feed_b`.
  - After the Nth weight, go to STREAM, or to FLUSH if the latched `len`=0.
  - `w_ready`=0 in all other states.
- Activation FIFO:
  - `a_ready` = not full, in every state including IDLE, so data can be prefetched.
  - Push on `a_valid & a_ready`.
  - Pop only in STREAM, when not empty and the remaining count > 0.
  - Simultaneous push and pop when full is not possible, because `a_ready`=0 when full.
  - Simultaneous push and pop when empty is not a bypass: the pushed word is popped on a later cycle.
  - Surplus activations beyond `len` stay in the FIFO for the next job.
- STREAM:
  - A pop registers `feed_a`←popped word and decrements the remaining count.
  - If the FIFO is empty, `feed_a`←0 (bubble) and the count is unchanged.
  - When the count reaches 0, go to FLUSH.
- FLUSH: `feed_a`←0 for exactly N cycles, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE. `start` is ignored here.
- `feed_b`, `feed_b_en`=0 outside LOAD_W.
- `feed_psum` is 0, or the latched bias (see Configuration).
- Counters: weight count is ⌈log2(N+1)⌉ bits; remaining count is 8 bits unsigned with no wrap (it stops at 0). FIFO pointers wrap modulo DEPTH, and a separate occupancy count of log2(DEPTH)+1 bits gives full/empty.

## Timing
- Reset values: `feed_a`=0, `feed_b`=0, `feed_b_en`=0, `feed_psum`=0, `busy`=0, `done`=0, `w_ready`=0, `a_ready`=0 while `rst`=0. The FIFO is emptied and the state is IDLE.
- First cycle after reset release: `a_ready`=1.
- Reset mid-job aborts immediately. Latched len/bias and FIFO contents are discarded.
- `start` at edge t: state is LOAD_W and `w_ready`=1 from t+1.
- Weight accepted at edge t: `feed_b_en`=1 and `feed_b`=w_data during cycle t+1.
- Activation popped at edge t: `feed_a` valid during cycle t+1.
- Minimum job duration (no stalls): 1 + N + len + N + 1 cycles, counted from the `start` edge through the `done` pulse.
- `done` is asserted in the cycle after the last flush cycle. `busy` falls together with `done`'s deassertion.

## Configuration
- `CONV_FEEDER_BIAS_EN` defined: `feed_psum` = bias latched at `start`, held for the whole job, and 0 in IDLE and after reset.
- `CONV_FEEDER_BIAS_EN` not defined: the `bias` port is present but ignored, and `feed_psum` is tied to 0.

## Test plan
- Reset: hold `rst`=0 with random inputs → all outputs 0. After release, `a_ready`=1 and `busy`=0.
- Basic job, N=3: push activations 1,2,3,4, start with `len`=4, send weights 5,6,7 back-to-back → `feed_b_en` high for 3 consecutive cycles with `feed_b`=5,6,7. `feed_a`=1,2,3,4 on consecutive cycles, then 0 for 3 cycles, then a `done` pulse. Total 12 cycles.
- FIFO boundaries, DEPTH=16: push 17 words while IDLE → `a_ready` drops after 16 accepted. In STREAM, an empty FIFO produces `feed_a`=0 bubbles and the count holds until data arrives.
- Edge cases: `len`=0 → LOAD_W then FLUSH N cycles, with no `feed_a` data. `start` during STREAM and DONE → ignored, and `len` is unchanged.
- Reset mid-operation: assert `rst`=0 during STREAM → immediate IDLE, FIFO empty, no `done`. A next job with fresh data runs correctly.
- Bias: with `CONV_FEEDER_BIAS_EN`, start with `bias`=8'h0A → `feed_psum`=8'h0A from LOAD_W through DONE, and 0 afterwards. Without the macro, `feed_psum`=0 throughout.

Source files
------------

// File: rtl/conv_operand_feeder_if.sv
// Weight and activation handshake bundle between an operand source and conv_operand_feeder.
// Handshake: a word transfers on a rising clk edge where valid && ready; the source holds data stable while valid && !ready.
interface conv_operand_feeder_if;
  logic       w_valid;
  logic       w_ready;
  logic [7:0] w_data;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] a_data;

  modport master (
    output w_valid, w_data, a_valid, a_data,
    input  w_ready, a_ready
  );

  modport slave (
    input  w_valid, w_data, a_valid, a_data,
    output w_ready, a_ready
  );
endinterface

// File: rtl/conv_operand_feeder.sv
// Operand feeder for a chain of N PEs: loads N weights, streams len activations from a FIFO, flushes N zeros, pulses done.
// Optional feature macro: CONV_FEEDER_BIAS_EN (feed_psum carries the bias latched at start).
module conv_operand_feeder #(
  parameter int N     = 3,
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] bias,
  conv_operand_feeder_if.slave bus,
  output logic [7:0] feed_a,
  output logic [7:0] feed_b,
  output logic       feed_b_en,
  output logic [7:0] feed_psum,
  output logic       busy,
  output logic       done,
  output logic [2:0] dbg_state
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WCW = $clog2(N + 1);
  localparam logic [WCW-1:0] LAST_CNT = WCW'(N - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     rem_q, rem_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [WCW-1:0] fcnt_q, fcnt_d;
  logic [7:0]     feed_a_q, feed_a_d;
  logic [7:0]     feed_b_q, feed_b_d;
  logic           feed_b_en_q, feed_b_en_d;
  logic [7:0]     psum_q, psum_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     mem_q [DEPTH];

  logic full, empty, push, pop, w_accept;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  // a_ready is gated by rst so the source sees no space while the block is held in reset.
  assign bus.a_ready = rst && !full;
  assign bus.w_ready = (state_q == S_LOAD_W);
  assign push     = bus.a_valid && bus.a_ready;
  assign pop      = (state_q == S_STREAM) && !empty && (rem_q != '0);
  assign w_accept = (state_q == S_LOAD_W) && bus.w_valid;

`ifndef CONV_FEEDER_BIAS_EN
  logic unused_bias;
  assign unused_bias = ^bias;
`endif

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    wcnt_d      = wcnt_q;
    fcnt_d      = fcnt_q;
    feed_a_d    = '0;
    feed_b_d    = '0;
    feed_b_en_d = 1'b0;
    psum_d      = psum_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_W;
          rem_d   = len;
          wcnt_d  = '0;
          fcnt_d  = '0;
`ifdef CONV_FEEDER_BIAS_EN
          psum_d  = bias;
`else
          psum_d  = '0;
`endif
        end
      end
      S_LOAD_W: begin
        feed_b_d = feed_b_q;
        if (w_accept) begin
          feed_b_d    = bus.w_data;
          feed_b_en_d = 1'b1;
          wcnt_d      = wcnt_q + 1'b1;
          if (wcnt_q == LAST_CNT) begin
            state_d = (rem_q == '0) ? S_FLUSH : S_STREAM;
          end
        end
      end
      S_STREAM: begin
        // An empty FIFO leaves feed_a at zero: a bubble the PE chain absorbs.
        if (pop) begin
          feed_a_d = mem_q[rd_ptr_q];
          rem_d    = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = S_FLUSH;
        end else if (rem_q == '0) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (fcnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        psum_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      wcnt_q      <= '0;
      fcnt_q      <= '0;
      feed_a_q    <= '0;
      feed_b_q    <= '0;
      feed_b_en_q <= 1'b0;
      psum_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      wcnt_q      <= wcnt_d;
      fcnt_q      <= fcnt_d;
      feed_a_q    <= feed_a_d;
      feed_b_q    <= feed_b_d;
      feed_b_en_q <= feed_b_en_d;
      psum_q      <= psum_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: the pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.a_data;
  end

  assign feed_a    = feed_a_q;
  assign feed_b    = feed_b_q;
  assign feed_b_en = feed_b_en_q;
  assign feed_psum = psum_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;
endmodule

// File: tb/tb_conv_operand_feeder.sv
// Directed bench for conv_operand_feeder: a per-cycle vector table for a basic job plus hand sequences for corner cases.
module tb_conv_operand_feeder;
  localparam int N     = 3;
  localparam int DEPTH = 16;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_W = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_FLUSH  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = '0;
  logic [7:0] bias = '0;
  logic [7:0] feed_a, feed_b, feed_psum;
  logic       feed_b_en, busy, done;
  logic [2:0] dbg_state;

  conv_operand_feeder_if bus();

  conv_operand_feeder #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .bias      (bias),
    .bus       (bus),
    .feed_a    (feed_a),
    .feed_b    (feed_b),
    .feed_b_en (feed_b_en),
    .feed_psum (feed_psum),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       start;
    logic [7:0] len;
    logic       w_valid;
    logic [7:0] w_data;
    logic [7:0] e_feed_a;
    logic [7:0] e_feed_b;
    logic       e_b_en;
    logic       e_w_ready;
    logic       e_busy;
    logic       e_done;
    logic       psum_on;
    logic [2:0] e_state;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic st, input logic [7:0] l, input logic wv, input logic [7:0] wd,
                              input logic [7:0] fa, input logic [7:0] fb, input logic ben, input logic wr,
                              input logic bz, input logic dn, input logic ps, input logic [2:0] s);
    vec_t v;
    v.start = st; v.len = l; v.w_valid = wv; v.w_data = wd;
    v.e_feed_a = fa; v.e_feed_b = fb; v.e_b_en = ben; v.e_w_ready = wr;
    v.e_busy = bz; v.e_done = dn; v.psum_on = ps; v.e_state = s;
    return v;
  endfunction

  function automatic logic [7:0] psum_exp(input logic on);
`ifdef CONV_FEEDER_BIAS_EN
    return on ? 8'h0A : 8'h00;
`else
    return on ? 8'h00 : 8'h00;
`endif
  endfunction

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    bus.a_valid = 1'b1;
    bus.a_data  = d;
    tick();
    bus.a_valid = 1'b0;
  endtask

  task automatic start_job(input logic [7:0] l, input logic [7:0] b);
    start = 1'b1;
    len   = l;
    bias  = b;
    tick();
    start = 1'b0;
    len   = '0;
  endtask

  task automatic send_weights(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
    logic [7:0] w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    for (int i = 0; i < N; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = w[i];
      tick();
    end
    bus.w_valid = 1'b0;
  endtask

  // Scoreboard: every nonzero feed_a must match the head of exp_q; done must arrive within the budget.
  task automatic run_to_done(input int bound, input string name);
    logic found;
    found = 1'b0;
    for (int c = 0; c < bound && !found; c++) begin
      tick();
      if (feed_a != 8'h00) begin
        if (exp_q.size() == 0) check({name, " unexpected feed_a"}, feed_a, 8'h00);
        else                   check({name, " feed_a"}, feed_a, exp_q.pop_front());
      end
      if (done) found = 1'b1;
    end
    check({name, " done seen"}, {7'd0, found}, 8'd1);
    check({name, " words left"}, 8'(exp_q.size()), 8'd0);
    exp_q.delete();
    tick();
    check({name, " back to idle"}, {5'd0, dbg_state}, {5'd0, ST_IDLE});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    bus.w_valid = 1'b0; bus.w_data = '0; bus.a_valid = 1'b0; bus.a_data = '0;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom_range(0, 1)); len = 8'($urandom_range(0, 255)); bias = 8'($urandom_range(0, 255));
      bus.w_valid = 1'($urandom_range(0, 1)); bus.w_data = 8'($urandom_range(0, 255));
      bus.a_valid = 1'($urandom_range(0, 1)); bus.a_data = 8'($urandom_range(0, 255));
      tick();
      check("rst feed_a", feed_a, 8'h00);
      check("rst feed_b", feed_b, 8'h00);
      check("rst feed_b_en", {7'd0, feed_b_en}, 8'd0);
      check("rst feed_psum", feed_psum, 8'h00);
      check("rst busy", {7'd0, busy}, 8'd0);
      check("rst done", {7'd0, done}, 8'd0);
      check("rst w_ready", {7'd0, bus.w_ready}, 8'd0);
      check("rst a_ready", {7'd0, bus.a_ready}, 8'd0);
    end
    start = 1'b0; len = '0; bias = '0;
    bus.w_valid = 1'b0; bus.a_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("post-rst a_ready", {7'd0, bus.a_ready}, 8'd1);
    check("post-rst busy", {7'd0, busy}, 8'd0);
    tick();

    // Basic job from a vector table
    //           st len wv wd    fa    fb    ben wr bz dn ps state
    vecs[0]  = mk(1, 4, 0, 0,    8'h0, 8'h0, 0,  1, 1, 0, 1, ST_LOAD_W);
    vecs[1]  = mk(0, 0, 1, 8'd5, 8'h0, 8'd5, 1,  1, 1, 0, 1, ST_LOAD_W);
    vecs[2]  = mk(0, 0, 1, 8'd6, 8'h0, 8'd6, 1,  1, 1, 0, 1, ST_LOAD_W);
    vecs[3]  = mk(0, 0, 1, 8'd7, 8'h0, 8'd7, 1,  0, 1, 0, 1, ST_STREAM);
    vecs[4]  = mk(0, 0, 0, 0,    8'd1, 8'h0, 0,  0, 1, 0, 1, ST_STREAM);
    vecs[5]  = mk(0, 0, 0, 0,    8'd2, 8'h0, 0,  0, 1, 0, 1, ST_STREAM);
    vecs[6]  = mk(0, 0, 0, 0,    8'd3, 8'h0, 0,  0, 1, 0, 1, ST_STREAM);
    vecs[7]  = mk(0, 0, 0, 0,    8'd4, 8'h0, 0,  0, 1, 0, 1, ST_FLUSH);
    vecs[8]  = mk(0, 0, 0, 0,    8'h0, 8'h0, 0,  0, 1, 0, 1, ST_FLUSH);
    vecs[9]  = mk(0, 0, 0, 0,    8'h0, 8'h0, 0,  0, 1, 0, 1, ST_FLUSH);
    vecs[10] = mk(0, 0, 0, 0,    8'h0, 8'h0, 0,  0, 1, 1, 1, ST_DONE);
    vecs[11] = mk(0, 0, 0, 0,    8'h0, 8'h0, 0,  0, 0, 0, 0, ST_IDLE);
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start; len = vecs[i].len;
      bias  = (i == 0) ? 8'h0A : 8'h55;
      bus.w_valid = vecs[i].w_valid; bus.w_data = vecs[i].w_data;
      tick();
      check($sformatf("v%0d feed_a", i), feed_a, vecs[i].e_feed_a);
      check($sformatf("v%0d feed_b", i), feed_b, vecs[i].e_feed_b);
      check($sformatf("v%0d feed_b_en", i), {7'd0, feed_b_en}, {7'd0, vecs[i].e_b_en});
      check($sformatf("v%0d w_ready", i), {7'd0, bus.w_ready}, {7'd0, vecs[i].e_w_ready});
      check($sformatf("v%0d busy", i), {7'd0, busy}, {7'd0, vecs[i].e_busy});
      check($sformatf("v%0d done", i), {7'd0, done}, {7'd0, vecs[i].e_done});
      check($sformatf("v%0d feed_psum", i), feed_psum, psum_exp(vecs[i].psum_on));
      check($sformatf("v%0d state", i), {5'd0, dbg_state}, {5'd0, vecs[i].e_state});
      check($sformatf("v%0d a_ready", i), {7'd0, bus.a_ready}, 8'd1);
    end
    start = 1'b0; bus.w_valid = 1'b0; bias = '0;

    // FIFO full: 17 offered in IDLE, 16 accepted, then drained by a len=16 job
    acc = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.a_valid = 1'b1;
      bus.a_data  = 8'h40 + 8'(i);
      if (bus.a_ready) acc++;
      tick();
    end
    bus.a_valid = 1'b0;
    check("full accepted", 8'(acc), 8'd16);
    check("full a_ready", {7'd0, bus.a_ready}, 8'd0);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'h40 + 8'(i));
    start_job(8'd16, 8'h00);
    send_weights(8'h11, 8'h12, 8'h13);
    run_to_done(60, "full job");

    // Empty FIFO in STREAM: bubbles, count holds, push+pop on empty is not a bypass
    start_job(8'd2, 8'h00);
    send_weights(8'h01, 8'h02, 8'h03);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bubble feed_a", feed_a, 8'h00);
      check("bubble state", {5'd0, dbg_state}, {5'd0, ST_STREAM});
    end
    push_word(8'h33);
    check("no bypass 1", feed_a, 8'h00);
    tick();
    check("late word 1", feed_a, 8'h33);
    check("late state 1", {5'd0, dbg_state}, {5'd0, ST_STREAM});
    push_word(8'h44);
    check("no bypass 2", feed_a, 8'h00);
    tick();
    check("late word 2", feed_a, 8'h44);
    check("late state 2", {5'd0, dbg_state}, {5'd0, ST_FLUSH});
    tick(); tick(); tick();
    check("bubble job done", {7'd0, done}, 8'd1);
    tick();

    // len=0: LOAD_W straight to FLUSH, prefetched word survives for next job
    push_word(8'h77);
    start_job(8'd0, 8'h00);
    send_weights(8'h09, 8'h08, 8'h07);
    for (int i = 0; i < N; i++) begin
      check("len0 state", {5'd0, dbg_state}, {5'd0, ST_FLUSH});
      check("len0 feed_a", feed_a, 8'h00);
      check("len0 done", {7'd0, done}, 8'd0);
      tick();
    end
    check("len0 done pulse", {7'd0, done}, 8'd1);
    tick();
    check("len0 idle", {7'd0, busy}, 8'd0);
    exp_q.push_back(8'h77);
    start_job(8'd1, 8'h00);
    send_weights(8'h01, 8'h01, 8'h01);
    run_to_done(20, "after len0");

    // start ignored in STREAM and DONE
    push_word(8'h21); push_word(8'h22); push_word(8'h23);
    start_job(8'd2, 8'h00);
    send_weights(8'h04, 8'h05, 8'h06);
    start = 1'b1; len = 8'd9;
    tick();
    start = 1'b0; len = '0;
    check("ign feed_a 1", feed_a, 8'h21);
    tick();
    check("ign feed_a 2", feed_a, 8'h22);
    check("ign len kept", {5'd0, dbg_state}, {5'd0, ST_FLUSH});
    tick(); tick(); tick();
    check("ign done", {7'd0, done}, 8'd1);
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0; len = '0;
    check("ign start in DONE", {5'd0, dbg_state}, {5'd0, ST_IDLE});
    check("ign busy", {7'd0, busy}, 8'd0);
    exp_q.push_back(8'h23);
    start_job(8'd1, 8'h00);
    send_weights(8'h01, 8'h01, 8'h01);
    run_to_done(20, "surplus job");

    // Reset mid-STREAM, then a fresh job
    push_word(8'h81); push_word(8'h82); push_word(8'h83);
    start_job(8'd3, 8'h0A);
    send_weights(8'h01, 8'h02, 8'h03);
    tick();
    check("mid feed_a", feed_a, 8'h81);
    rst = 1'b0;
    #1;
    check("mid rst busy", {7'd0, busy}, 8'd0);
    check("mid rst feed_a", feed_a, 8'h00);
    check("mid rst state", {5'd0, dbg_state}, {5'd0, ST_IDLE});
    check("mid rst psum", feed_psum, 8'h00);
    tick();
    check("mid rst done", {7'd0, done}, 8'd0);
    rst = 1'b1;
    #1;
    check("mid rel a_ready", {7'd0, bus.a_ready}, 8'd1);
    tick();
    push_word(8'h91); push_word(8'h92);
    exp_q.push_back(8'h91); exp_q.push_back(8'h92);
    start_job(8'd2, 8'h00);
    send_weights(8'h01, 8'h02, 8'h03);
    run_to_done(20, "post-rst job");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
